// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-port memory responder.
// Holds bus widths, the active levels of the data-port handshake signals,
// the access-size and FSM state encodings, the captured request payload,
// and the natural-alignment helper used by the byte-lane logic.
package data_mem_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned WLEN_W = 2;
  localparam int unsigned BYTES  = XLEN / 8;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned CNT_W  = 4;

  // Active levels of the data-port handshake signals
  localparam logic RDATA_EN    = 1'b1;
  localparam logic WDATA_EN    = 1'b1;
  localparam logic WDATA_READY = 1'b1;
  localparam logic RDATA_VALID = 1'b1;

  typedef enum logic [1:0] {
    WLEN_BYTE  = 2'd0,
    WLEN_HALF  = 2'd1,
    WLEN_WORD  = 2'd2,
    WLEN_DWORD = 2'd3
  } wlen_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    wlen_e             wlen;
    logic              is_write;
  } dmem_req_t;

  // Force the low offset bits to zero so the access is naturally aligned
  function automatic logic [OFF_W-1:0] align_offset(input logic [OFF_W-1:0] off,
                                                    input wlen_e            wlen);
    logic [OFF_W-1:0] res;
    res = '0;
    case (wlen)
      WLEN_BYTE: res = off;
      WLEN_HALF: res = {off[2:1], 1'b0};
      WLEN_WORD: res = {off[2], 2'b00};
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_byte_lane.sv
// Byte-lane steering for a dword-organised RAM (pure combinational).
// Ports:
//   offset          - byte offset within the dword (addr[2:0])
//   wlen            - access size: byte/half/word/dword
//   wdata           - LSB-justified write data
//   rdword          - full dword read from RAM
//   byte_en_c       - per-byte write enable within the dword
//   wdata_aligned_c - write data shifted into its byte lanes
//   rdata_c         - read data extracted, LSB-justified, zero-extended
module mem_byte_lane
  import data_mem_responder_pkg::*;
(
  input  logic [OFF_W-1:0] offset,
  input  wlen_e            wlen,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdword,
  output logic [BYTES-1:0] byte_en_c,
  output logic [XLEN-1:0]  wdata_aligned_c,
  output logic [XLEN-1:0]  rdata_c
);

  logic [OFF_W-1:0] off_al;
  logic [5:0]       shamt;
  logic [BYTES-1:0] base_en;
  logic [XLEN-1:0]  size_mask;

  // Size-dependent mask, shifted into place by the aligned offset
  always_comb begin
    base_en   = 8'h01;
    size_mask = 64'h0000_0000_0000_00FF;
    off_al    = align_offset(offset, wlen);
    shamt     = {off_al, 3'b000};
    case (wlen)
      WLEN_BYTE: begin
        base_en   = 8'h01;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      WLEN_HALF: begin
        base_en   = 8'h03;
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      WLEN_WORD: begin
        base_en   = 8'h0F;
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        base_en   = 8'hFF;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
    byte_en_c       = BYTES'(base_en << off_al);
    wdata_aligned_c = XLEN'(wdata << shamt);
    rdata_c         = XLEN'(rdword >> shamt) & size_mask;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder terminating the shared data port in on-chip RAM.
// A request is captured in IDLE, held for LATENCY cycles, and answered with
// a single-cycle registered wdata_ready_out or rdata_valid_out pulse.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   data_addr_in     - byte address (index = addr[DEPTH_LOG2+2:3], aliases above)
//   rdata_en_in      - read request
//   wdata_en_in      - write request (wins when both enables are active)
//   wdata_in         - LSB-justified write data
//   wlen_in          - access size: 0=byte, 1=half, 2=word, 3=dword
//   wdata_ready_out  - write-complete pulse
//   rdata_out        - read data, non-zero only during the read pulse
//   rdata_valid_out  - read-complete pulse
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] data_addr_in,
  input  logic              rdata_en_in,
  input  logic              wdata_en_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic [WLEN_W-1:0] wlen_in,
  output logic              wdata_ready_out,
  output logic [XLEN-1:0]   rdata_out,
  output logic              rdata_valid_out
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_LSB = 3;
  localparam int unsigned IDX_MSB = DEPTH_LOG2 + 2;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d, live_req, cur_req;
  logic             req_present_c;
  logic             enter_resp_c;
  logic             mem_we_c;
  logic             rd_load_c;
  logic             wready_d;
  logic             rvalid_d;
  logic [XLEN-1:0]  rdata_d;

  logic [XLEN-1:0]       mem [DEPTH];
  logic [XLEN-1:0]       rd_dword_q;
  logic [DEPTH_LOG2-1:0] idx;
  logic [BYTES-1:0]      lane_byte_en;
  logic [XLEN-1:0]       lane_wdata;
  logic [XLEN-1:0]       lane_rdata;
  logic                  unused_addr_bits;

  // Request as presented on the port this cycle
  always_comb begin
    live_req          = '0;
    live_req.addr     = data_addr_in;
    live_req.wdata    = wdata_in;
    live_req.wlen     = wlen_e'(wlen_in);
    live_req.is_write = (wdata_en_in == WDATA_EN);
  end

  assign req_present_c = (rdata_en_in == RDATA_EN) || (wdata_en_in == WDATA_EN);

  // With LATENCY=1 the RAM access happens on the capture edge, so IDLE uses the live port
  assign cur_req = (state_q == DMEM_IDLE) ? live_req : req_q;
  assign idx     = cur_req.addr[IDX_MSB:IDX_LSB];

  // Address bits above the RAM index alias by design
  assign unused_addr_bits = ^cur_req.addr[ADDR_W-1:IDX_MSB+1];

  mem_byte_lane u_lane (
    .offset          (cur_req.addr[OFF_W-1:0]),
    .wlen            (cur_req.wlen),
    .wdata           (cur_req.wdata),
    .rdword          (rd_dword_q),
    .byte_en_c       (lane_byte_en),
    .wdata_aligned_c (lane_wdata),
    .rdata_c         (lane_rdata)
  );

  // Next-state and response decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    enter_resp_c = 1'b0;
    wready_d     = 1'b0;
    rvalid_d     = 1'b0;
    rdata_d      = '0;
    case (state_q)
      DMEM_IDLE: begin
        if (req_present_c) begin
          req_d = live_req;
          if (LATENCY > 1) begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end else begin
            state_d      = DMEM_RESP;
            enter_resp_c = 1'b1;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = DMEM_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DMEM_RESP: begin
        state_d = DMEM_IDLE;
        if (req_q.is_write) begin
          wready_d = 1'b1;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = lane_rdata;
        end
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
    mem_we_c  = enter_resp_c && cur_req.is_write;
    rd_load_c = enter_resp_c && !cur_req.is_write;
  end

  // FSM state, captured request and registered response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= DMEM_IDLE;
      cnt_q           <= '0;
      req_q           <= '0;
      wdata_ready_out <= 1'b0;
      rdata_valid_out <= 1'b0;
      rdata_out       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
      wdata_ready_out <= wready_d ? WDATA_READY : !WDATA_READY;
      rdata_valid_out <= rvalid_d ? RDATA_VALID : !RDATA_VALID;
      rdata_out       <= rdata_d;
    end
  end

  // RAM array (not reset); rstn gates accesses so a held request cannot commit during reset
  always_ff @(posedge clk) begin
    if (mem_we_c && rstn) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (lane_byte_en[b]) begin
          mem[idx][b*8 +: 8] <= lane_wdata[b*8 +: 8];
        end
      end
    end
    if (rd_load_c && rstn) begin
      rd_dword_q <= mem[idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance at LATENCY=1 and
// one at LATENCY=4, compared against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int DW_LOG2 = 6;
  localparam int MEM_DW  = 1 << DW_LOG2;

  logic        clk;
  logic        rstn   [2];
  logic [31:0] addr   [2];
  logic        rd_en  [2];
  logic        wr_en  [2];
  logic [63:0] wdata  [2];
  logic [1:0]  wlen   [2];
  logic        wready [2];
  logic        rvalid [2];
  logic [63:0] rdata  [2];

  logic [63:0] model_mem [2][MEM_DW];

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder #(.DEPTH_LOG2(DW_LOG2), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn[0]), .data_addr_in(addr[0]), .rdata_en_in(rd_en[0]),
    .wdata_en_in(wr_en[0]), .wdata_in(wdata[0]), .wlen_in(wlen[0]),
    .wdata_ready_out(wready[0]), .rdata_out(rdata[0]), .rdata_valid_out(rvalid[0])
  );

  data_mem_responder #(.DEPTH_LOG2(DW_LOG2), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rstn(rstn[1]), .data_addr_in(addr[1]), .rdata_en_in(rd_en[1]),
    .wdata_en_in(wr_en[1]), .wdata_in(wdata[1]), .wlen_in(wlen[1]),
    .wdata_ready_out(wready[1]), .rdata_out(rdata[1]), .rdata_valid_out(rvalid[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference model: the access covers 2^wlen consecutive bytes from the aligned address
  function automatic logic [63:0] m_read(input int d, input logic [31:0] a, input logic [1:0] wl);
    int n, base, idx;
    logic [63:0] r;
    n    = 1 << wl;
    base = (int'(a[2:0]) / n) * n;
    idx  = int'(a[DW_LOG2+2:3]);
    r    = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = model_mem[d][idx][(base+i)*8 +: 8];
    return r;
  endfunction

  task automatic m_write(input int d, input logic [31:0] a, input logic [1:0] wl, input logic [63:0] wd);
    int n, base, idx;
    n    = 1 << wl;
    base = (int'(a[2:0]) / n) * n;
    idx  = int'(a[DW_LOG2+2:3]);
    for (int i = 0; i < n; i++) model_mem[d][idx][(base+i)*8 +: 8] = wd[i*8 +: 8];
  endtask

  task automatic set_req(input int d, input logic [31:0] a, input logic r, input logic w,
                         input logic [1:0] wl, input logic [63:0] wd);
    addr[d] = a; rd_en[d] = r; wr_en[d] = w; wlen[d] = wl; wdata[d] = wd;
  endtask

  task automatic idle_req(input int d);
    addr[d] = '0; rd_en[d] = 1'b0; wr_en[d] = 1'b0; wlen[d] = '0; wdata[d] = '0;
  endtask

  // Watch n cycles; any pulse or non-zero rdata is a violation
  task automatic quiet(input int d, input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (wready[d] || rvalid[d] || rdata[d] != 64'd0) bad++;
    end
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  // One request, held until its pulse; checks latency, pulse kind, data and silence after
  task automatic txn(input int d, input logic [31:0] a, input logic r, input logic w,
                     input logic [1:0] wl, input logic [63:0] wd, output logic [63:0] got);
    int lat, first, pulses, strays;
    logic [63:0] exp_rd;
    lat    = lat_of(d);
    first  = -1;
    pulses = 0;
    strays = 0;
    got    = '0;
    exp_rd = w ? 64'd0 : m_read(d, a, wl);
    @(negedge clk);
    set_req(d, a, r, w, wl, wd);
    @(posedge clk);
    for (int c = 1; c <= lat + 2; c++) begin
      @(posedge clk); #1;
      if (wready[d] || rvalid[d]) begin
        pulses++;
        if (first < 0) first = c;
        got = rdata[d];
        check_eq("pulse_wready", 64'(wready[d]), 64'(w));
        check_eq("pulse_rvalid", 64'(rvalid[d]), 64'(!w));
        check_eq("pulse_rdata", rdata[d], exp_rd);
        idle_req(d);
      end else if (rdata[d] != 64'd0) begin
        strays++;
      end
    end
    idle_req(d);
    check_eq("latency", 64'(first), 64'(lat));
    check_eq("pulse_count", 64'(pulses), 64'd1);
    check_eq("rdata_outside_pulse", 64'(strays), 64'd0);
    if (w) m_write(d, a, wl, wd);
  endtask

  initial begin : main
    logic [63:0] got, exp, old, newd, mask;
    logic [31:0] a;
    int npulse, sel;

    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0;
      idle_req(d);
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_wready", 64'(wready[d]), 64'd0);
      check_eq("reset_rvalid", 64'(rvalid[d]), 64'd0);
      check_eq("reset_rdata", rdata[d], 64'd0);
    end
    @(negedge clk);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    quiet(0, 4, "idle_quiet_l1");
    quiet(1, 4, "idle_quiet_l4");

    // Preload every dword so all later reads have a known expectation
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < MEM_DW; i++)
        txn(d, 32'(i * 8), 1'b0, 1'b1, 2'd3, {$urandom, $urandom}, got);

    // Dword round trip
    for (int d = 0; d < 2; d++) begin
      txn(d, 32'h100, 1'b0, 1'b1, 2'd3, 64'h1122334455667788, got);
      txn(d, 32'h100, 1'b1, 1'b0, 2'd3, 64'd0, got);
      check_eq("dword_roundtrip", got, 64'h1122334455667788);
    end

    // Byte lanes
    txn(0, 32'h100, 1'b0, 1'b1, 2'd3, 64'd0, got);
    txn(0, 32'h103, 1'b0, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, got);
    txn(0, 32'h100, 1'b1, 1'b0, 2'd3, 64'd0, got);
    check_eq("lane_dword", got, 64'h0000_0000_AB00_0000);
    txn(0, 32'h102, 1'b1, 1'b0, 2'd1, 64'd0, got);
    check_eq("lane_half_hi", got, 64'h0000_0000_0000_AB00);
    txn(0, 32'h101, 1'b1, 1'b0, 2'd1, 64'd0, got);
    check_eq("lane_half_unaligned", got, 64'h0);

    // Both enables: write wins
    for (int d = 0; d < 2; d++) begin
      txn(d, 32'h8, 1'b1, 1'b1, 2'd2, 64'hDEADBEEF, got);
      txn(d, 32'h8, 1'b1, 1'b0, 2'd2, 64'd0, got);
      check_eq("both_en_readback", got, 64'h0000_0000_DEAD_BEEF);
    end

    // Held request at LATENCY=4: pulses at k+4 and k+9 only
    exp = m_read(1, 32'h40, 2'd3);
    @(negedge clk);
    set_req(1, 32'h40, 1'b1, 1'b0, 2'd3, 64'd0);
    @(posedge clk);
    mask = '0;
    npulse = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (wready[1] || rvalid[1]) begin
        mask |= 64'd1 << c;
        check_eq("held_rdata", rdata[1], exp);
        npulse++;
        if (npulse == 2) idle_req(1);
      end
    end
    idle_req(1);
    check_eq("held_pulse_cycles", mask, (64'd1 << 4) | (64'd1 << 9));

    // Asynchronous reset clears a live pulse immediately
    exp = m_read(1, 32'h48, 2'd3);
    @(negedge clk);
    set_req(1, 32'h48, 1'b1, 1'b0, 2'd3, 64'd0);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_eq("async_pre_rvalid", 64'(rvalid[1]), 64'd1);
    check_eq("async_pre_rdata", rdata[1], exp);
    #2;
    rstn[1] = 1'b0;
    #1;
    check_eq("async_rvalid", 64'(rvalid[1]), 64'd0);
    check_eq("async_rdata", rdata[1], 64'd0);
    check_eq("async_wready", 64'(wready[1]), 64'd0);
    idle_req(1);
    @(negedge clk);
    rstn[1] = 1'b1;
    quiet(1, 6, "async_post_quiet");

    // Reset during WAIT drops the uncommitted write
    a    = 32'h50;
    old  = m_read(1, a, 2'd3);
    newd = ~old;
    @(negedge clk);
    set_req(1, a, 1'b0, 1'b1, 2'd3, newd);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    rstn[1] = 1'b0;
    idle_req(1);
    #1;
    check_eq("wait_rst_wready", 64'(wready[1]), 64'd0);
    @(negedge clk);
    rstn[1] = 1'b1;
    quiet(1, 6, "wait_rst_quiet");
    txn(1, a, 1'b1, 1'b0, 2'd3, 64'd0, got);
    check_eq("wait_rst_unchanged", got, old);

    // LATENCY=1: the write has committed before the reset
    a    = 32'h58;
    newd = ~m_read(0, a, 2'd3);
    txn(0, a, 1'b0, 1'b1, 2'd3, newd, got);
    @(posedge clk); #1;
    rstn[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    txn(0, a, 1'b1, 1'b0, 2'd3, 64'd0, got);
    check_eq("l1_rst_kept", got, newd);

    // Random traffic; full 32-bit addresses exercise index aliasing
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      txn($urandom_range(0, 1), $urandom, sel != 1, sel == 1 || sel == 2,
          2'($urandom_range(0, 3)), {$urandom, $urandom}, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
